// File: rtl/spiking_delay_layer.sv
// Layer of N leaky integrate-and-fire neurons fed by M delayed spike inputs.
// Ports: clk/reset/enable/step control, spikes, weights, delays, constants; pots, spikes, valid out.
module spiking_delay_layer #(
  parameter int M     = 2,
  parameter int N     = 4,
  parameter int NBITS = 4,
  parameter int DMAX  = 7,
  localparam int DW   = $clog2(DMAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   step,
  input  logic                   reset_mode,
  input  logic [M-1:0]           input_spikes,
  input  logic [N*M*NBITS-1:0]   weights,
  input  logic [N*M*DW-1:0]      delay_values,
  input  logic [NBITS-1:0]       threshold,
  input  logic [NBITS-1:0]       decay,
  input  logic [NBITS-1:0]       refractory_period,
  output logic [N*NBITS-1:0]     membrane_potential_out,
  output logic [N-1:0]           output_spikes,
  output logic                   spikes_valid
);

  // Wide enough for a full potential plus M full weights without wrap.
  localparam int AW = NBITS + $clog2(M + 1) + 1;
  localparam logic [AW-1:0] SATV = AW'((1 << NBITS) - 1);

  logic [M-1:0][DMAX-1:0]  hist_q, hist_d;
  logic [N-1:0][NBITS-1:0] pot_q, pot_d;
  logic [N-1:0][NBITS-1:0] ref_q, ref_d;
  logic [N-1:0]            spk_q, spk_d;
  logic                    valid_q, valid_d;

  logic             accept;
  logic [AW-1:0]    acc;
  logic [NBITS-1:0] sat;
  logic [DW-1:0]    dsel;
  logic             dspk;
  int               didx;

  always_comb begin
    accept  = step & enable & ~reset;
    hist_d  = hist_q;
    pot_d   = pot_q;
    ref_d   = ref_q;
    spk_d   = spk_q;
    valid_d = accept;
    acc     = '0;
    sat     = '0;
    dsel    = '0;
    dspk    = 1'b0;
    didx    = 0;
    if (accept) begin
      for (int n = 0; n < N; n++) begin
        if (ref_q[n] != '0) begin
          ref_d[n] = ref_q[n] - 1'b1;
          pot_d[n] = '0;
          spk_d[n] = 1'b0;
        end else begin
          acc = (pot_q[n] > decay) ? AW'(pot_q[n] - decay) : '0;
          for (int m = 0; m < M; m++) begin
            dsel = delay_values[(n*M+m)*DW +: DW];
            // History bit k holds the input from k+1 steps ago.
            if (dsel == '0) begin
              dspk = input_spikes[m];
            end else begin
              didx = (int'(dsel) > DMAX) ? DMAX - 1 : int'(dsel) - 1;
              dspk = hist_q[m][didx];
            end
            if (dspk)
              acc = acc + AW'(weights[(n*M+m)*NBITS +: NBITS]);
          end
          sat = (acc > SATV) ? '1 : acc[NBITS-1:0];
          if (sat >= threshold) begin
            spk_d[n] = 1'b1;
            ref_d[n] = refractory_period;
            pot_d[n] = reset_mode ? sat - threshold : '0;
          end else begin
            spk_d[n] = 1'b0;
            pot_d[n] = sat;
          end
        end
      end
      for (int m = 0; m < M; m++)
        hist_d[m] = DMAX'({hist_q[m], input_spikes[m]});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      pot_q   <= '0;
      ref_q   <= '0;
      spk_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pot_q   <= pot_d;
      ref_q   <= ref_d;
      spk_q   <= spk_d;
      valid_q <= valid_d;
    end
  end

  assign membrane_potential_out = pot_q;
  assign output_spikes          = spk_q;
  assign spikes_valid           = valid_q;

endmodule

// File: tb/tb_spiking_delay_layer.sv
// Bench for spiking_delay_layer: timestep model compared every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_spiking_delay_layer;
  localparam int M = 2, N = 2, NB = 4, DMAX = 7, DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, step, reset_mode;
  logic [M-1:0]      input_spikes;
  logic [N*M*NB-1:0] weights;
  logic [N*M*DW-1:0] delay_values;
  logic [NB-1:0]     threshold, decay, refractory_period;
  logic [N*NB-1:0]   membrane_potential_out;
  logic [N-1:0]      output_spikes;
  logic              spikes_valid;

  spiking_delay_layer #(.M(M), .N(N), .NBITS(NB), .DMAX(DMAX)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .reset_mode(reset_mode), .input_spikes(input_spikes),
    .weights(weights), .delay_values(delay_values),
    .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period),
    .membrane_potential_out(membrane_potential_out),
    .output_spikes(output_spikes), .spikes_valid(spikes_valid)
  );

  int tests = 0, fails = 0;
  bit chk = 0;
  int w_arr[N][M], d_arr[N][M];
  int thr, dec, rp, rmode;
  int pin[M][DMAX+1];
  int m_pot[N], m_ref[N], m_spk[N];
  int m_valid;

  task automatic clr_cfg();
    for (int n = 0; n < N; n++)
      for (int m = 0; m < M; m++) begin
        w_arr[n][m] = 0;
        d_arr[n][m] = 0;
      end
    thr = 5; dec = 0; rp = 0; rmode = 0;
  endtask

  task automatic drive_cfg();
    for (int n = 0; n < N; n++)
      for (int m = 0; m < M; m++) begin
        weights[(n*M+m)*NB +: NB]      = NB'(w_arr[n][m]);
        delay_values[(n*M+m)*DW +: DW] = DW'(d_arr[n][m]);
      end
    threshold = NB'(thr);
    decay = NB'(dec);
    refractory_period = NB'(rp);
    reset_mode = rmode[0];
  endtask

  // Spike seen by synapse (n,m) this timestep; pin[m][k] = input k steps ago.
  function automatic int dspk(int n, int m);
    int d = d_arr[n][m];
    if (d == 0) return int'(input_spikes[m]);
    if (d > DMAX) d = DMAX;
    return pin[m][d];
  endfunction

  task automatic model();
    if (reset) begin
      for (int m = 0; m < M; m++)
        for (int k = 0; k <= DMAX; k++) pin[m][k] = 0;
      for (int n = 0; n < N; n++) begin
        m_pot[n] = 0; m_ref[n] = 0; m_spk[n] = 0;
      end
      m_valid = 0;
    end else if (step && enable) begin
      for (int n = 0; n < N; n++) begin
        if (m_ref[n] > 0) begin
          m_ref[n]--; m_pot[n] = 0; m_spk[n] = 0;
        end else begin
          int acc = m_pot[n] - dec;
          if (acc < 0) acc = 0;
          for (int m = 0; m < M; m++) acc += w_arr[n][m] * dspk(n, m);
          if (acc > 15) acc = 15;
          if (acc >= thr) begin
            m_spk[n] = 1; m_ref[n] = rp;
            m_pot[n] = (rmode != 0) ? acc - thr : 0;
          end else begin
            m_spk[n] = 0; m_pot[n] = acc;
          end
        end
      end
      for (int m = 0; m < M; m++) begin
        for (int k = DMAX; k >= 2; k--) pin[m][k] = pin[m][k-1];
        pin[m][1] = int'(input_spikes[m]);
      end
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit s,
                     input logic [M-1:0] in);
    @(negedge clk);
    reset = r; enable = e; step = s; input_spikes = in;
    drive_cfg();
    model();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pot(int n);
    return int'(membrane_potential_out[n*NB +: NB]);
  endfunction

  initial begin
    forever begin
      logic [N*NB-1:0] ep;
      logic [N-1:0]    es;
      @(posedge clk);
      #1;
      if (chk) begin
        for (int n = 0; n < N; n++) begin
          ep[n*NB +: NB] = NB'(m_pot[n]);
          es[n] = m_spk[n][0];
        end
        tests += 3;
        if (membrane_potential_out !== ep) begin
          fails++;
          $display("FAIL cyc_pot: got %h expected %h",
                   membrane_potential_out, ep);
        end
        if (output_spikes !== es) begin
          fails++;
          $display("FAIL cyc_spk: got %b expected %b", output_spikes, es);
        end
        if (spikes_valid !== m_valid[0]) begin
          fails++;
          $display("FAIL cyc_valid: got %b expected %0d",
                   spikes_valid, m_valid);
        end
      end
    end
  end

  initial begin
    reset = 1; enable = 0; step = 0; input_spikes = '0;
    clr_cfg();
    drive_cfg();
    cyc(1, 0, 0, 2'b00);
    cyc(1, 1, 1, 2'b01);
    chk = 1;
    lit("rst_pot", int'(membrane_potential_out), 0);
    lit("rst_spk", int'(output_spikes), 0);
    lit("rst_valid", int'(spikes_valid), 0);

    // Integrate then fire on back-to-back steps.
    w_arr[0][0] = 3;
    cyc(0, 1, 1, 2'b01);
    lit("s1_pot", pot(0), 3);
    lit("s1_mpot", m_pot[0], 3);
    lit("s1_valid", int'(spikes_valid), 1);
    cyc(0, 1, 0, 2'b00);
    lit("s1_hold", pot(0), 3);
    lit("s1_idle_valid", int'(spikes_valid), 0);
    cyc(0, 1, 1, 2'b01);
    lit("s2_pot", pot(0), 0);
    lit("s2_spk", int'(output_spikes[0]), 1);
    cyc(0, 1, 1, 2'b01);
    lit("s3_pot", pot(0), 3);

    // Delay of 3 steps on synapse (1,1).
    cyc(1, 1, 0, 2'b00);
    clr_cfg();
    w_arr[1][1] = 6; d_arr[1][1] = 3;
    cyc(0, 1, 1, 2'b10);
    lit("dly_k", int'(output_spikes[1]), 0);
    cyc(0, 1, 1, 2'b00);
    cyc(0, 1, 1, 2'b00);
    lit("dly_k2", int'(output_spikes[1]), 0);
    cyc(0, 1, 1, 2'b00);
    lit("dly_k3", int'(output_spikes[1]), 1);
    lit("dly_m", m_spk[1], 1);
    lit("dly_valid", int'(spikes_valid), 1);
    cyc(0, 1, 1, 2'b00);
    lit("dly_k4", int'(output_spikes[1]), 0);

    // Refractory period of 2.
    cyc(1, 1, 0, 2'b00);
    clr_cfg();
    rp = 2; w_arr[0][0] = 6;
    cyc(0, 1, 1, 2'b01);
    lit("ref_fire", int'(output_spikes[0]), 1);
    cyc(0, 1, 1, 2'b01);
    lit("ref1_spk", int'(output_spikes[0]), 0);
    lit("ref1_pot", pot(0), 0);
    cyc(0, 1, 1, 2'b01);
    lit("ref2_spk", int'(output_spikes[0]), 0);
    w_arr[0][0] = 3;
    cyc(0, 1, 1, 2'b01);
    lit("ref3_pot", pot(0), 3);

    // Subtractive reset and saturation.
    cyc(1, 1, 0, 2'b00);
    clr_cfg();
    rmode = 1; w_arr[0][0] = 9;
    cyc(0, 1, 1, 2'b01);
    lit("sub_spk", int'(output_spikes[0]), 1);
    lit("sub_pot", pot(0), 4);
    cyc(1, 1, 0, 2'b00);
    w_arr[0][0] = 15; w_arr[0][1] = 15;
    cyc(0, 1, 1, 2'b11);
    lit("sat_sub_pot", pot(0), 10);
    cyc(1, 1, 0, 2'b00);
    thr = 15; rmode = 0;
    cyc(0, 1, 1, 2'b11);
    lit("sat_spk", int'(output_spikes[0]), 1);
    lit("sat_pot", pot(0), 0);

    // Decay floors at zero; enable low freezes everything.
    cyc(1, 1, 0, 2'b00);
    clr_cfg();
    thr = 15; dec = 2; w_arr[0][0] = 1;
    cyc(0, 1, 1, 2'b01);
    lit("dec_pot1", pot(0), 1);
    cyc(0, 1, 1, 2'b00);
    lit("dec_floor", pot(0), 0);
    dec = 0; w_arr[0][0] = 3;
    cyc(0, 1, 1, 2'b01);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'b01);
    lit("en_hold", pot(0), 3);
    lit("en_valid", int'(spikes_valid), 0);

    // Threshold zero fires every neuron.
    cyc(1, 1, 0, 2'b00);
    clr_cfg();
    thr = 0;
    cyc(0, 1, 1, 2'b00);
    lit("thr0_spk", int'(output_spikes), 3);

    // Reset with step pending discards delayed spike.
    cyc(1, 1, 0, 2'b00);
    clr_cfg();
    w_arr[1][1] = 6; d_arr[1][1] = 3;
    cyc(0, 1, 1, 2'b10);
    cyc(0, 1, 1, 2'b00);
    cyc(1, 1, 1, 2'b00);
    lit("rst_mid_spk", int'(output_spikes), 0);
    lit("rst_mid_pot", int'(membrane_potential_out), 0);
    lit("rst_mid_valid", int'(spikes_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 2'b00);
      lit("rst_no_ghost", int'(output_spikes[1]), 0);
    end

    cyc(0, 1, 0, 2'b00);
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
